mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences variable-latency data-memory accesses for the MEM stage of the five-stage pipeline.
- Latches the load/store request held in the EX/MEM register and drives a req/ack handshake to data memory.
- Stalls the front pipeline registers while the access is in flight.
- Forces a bubble into MEM/WB until the access completes, then hands the load data to MEM/WB's readMem input.

Parameters:
- DSIZE, 16, data width; matches the pipeline data word.
- MAW, 8, data-memory address width.
- TIMEOUT, 15, maximum cycles in REQ without ack before the access is aborted; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_req_valid  in  1  EX/MEM holds a load or store
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  MAW  access address from EX/MEM
- mem_wdata  in  DSIZE  store data from EX/MEM
- dmem_req  out  1  request to data memory, registered
- dmem_we  out  1  write enable to memory, registered
- dmem_addr  out  MAW  address to memory, registered
- dmem_wdata  out  DSIZE  write data to memory, registered
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  DSIZE  read data, valid when dmem_ack=1
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mwb_bubble  out  1  force MEM/WB wen_in=0 and MemtoReg_in=0
- load_data  out  DSIZE  registered load result; drives MEM/WB readMem_in
- load_valid  out  1  load_data is valid this cycle
- bus_err  out  1  one-cycle pulse: access aborted by timeout

Behaviour:
- Reset: clk and rst as decided; rst is synchronous and active-high.
  - State goes to IDLE; timeout counter goes to 0.
  - All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, load_valid, bus_err.
  - stall and mwb_bubble decode from state, so they read 0 the cycle after reset.
  - Reset mid-access abandons the access; any later dmem_ack is ignored.
- States: IDLE, REQ, DONE, ERR; 2-bit encoding.
- IDLE:
  - When mem_req_valid=1: latch mem_we, mem_addr and mem_wdata into the dmem_* registers, set dmem_req=1, clear the counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dmem_req stays 1; dmem_we, dmem_addr and dmem_wdata stay stable.
  - The counter increments each cycle without ack.
  - On dmem_ack=1: clear dmem_req. For a load, load_data<=dmem_rdata and load_valid<=1. Go to DONE.
  - If the counter reaches TIMEOUT with dmem_ack=0: clear dmem_req, set load_data<=0, bus_err<=1, go to ERR.
  - dmem_ack in the same cycle the counter reaches TIMEOUT: ack wins.
- DONE and ERR:
  - Last for one cycle, then go to IDLE.
  - load_valid and bus_err clear on that exit edge.
  - mem_req_valid is ignored in these states; it still reflects the completing op.
- Store: load_valid stays 0 throughout; load_data is unchanged.
- Stall and bubble (combinational):
  - stall = (IDLE & mem_req_valid) | REQ.
  - mwb_bubble = stall.
  - In DONE and ERR, stall=0, so the pipeline advances and MEM/WB captures the completed op.
- dmem_ack outside REQ is ignored.
- Latency (ack-to-ack):
  - Minimum access = 3 cycles with stall high for 2 (IDLE-detect cycle, then REQ with immediate ack), followed by 1 DONE cycle.
  - Back-to-back memory ops: the next op starts its IDLE detect one cycle after DONE.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package (or define.v extension) holds:
  - the state encodings ST_IDLE, ST_REQ, ST_DONE, ST_ERR;
  - DSIZE and MAW defaults.
- One sub-module, mem_timeout_cnt: clear/enable saturating counter with a hit output at TIMEOUT.

Test Plan:
- Load, ack after 2 REQ cycles, addr=8'h10, rdata=16'hBEEF:
  - stall high for 3 cycles;
  - DONE cycle has load_data=16'hBEEF, load_valid=1, stall=0;
  - bus_err=0.
- Store, addr=8'h20, wdata=16'h1234, ack on the first REQ cycle:
  - dmem_we=1 and the addr/data held stable while dmem_req=1;
  - load_valid stays 0; stall high for 2 cycles.
- No ack, TIMEOUT=15:
  - dmem_req falls after 15 REQ cycles;
  - bus_err pulses for exactly 1 cycle; load_data=0; stall released in ERR.
- Ack in the same cycle the counter reaches TIMEOUT: DONE taken, load_data=rdata, bus_err=0.
- rst asserted on the 2nd REQ cycle, ack pulsed 1 cycle later:
  - all outputs are 0 after the reset edge;
  - FSM in IDLE; the late ack causes no load_valid.
- Two consecutive loads with mem_req_valid held high:
  - mem_req_valid is ignored in DONE;
  - the second dmem_req rises 2 cycles after the first DONE;
  - exactly 2 load_valid pulses.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer.
package mem_access_ctrl_pkg;

  localparam int DSIZE_DEF   = 16;
  localparam int MAW_DEF     = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for an outstanding memory request.
// o_hit is high in the enabled cycle whose increment makes the count reach
// TIMEOUT, so the owner can abort on that same edge.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Clear on reset or new request; count enabled cycles, holding at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = i_en && (r_cnt >= LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: latches the EX/MEM load/store,
// runs a req/ack handshake to data memory, stalls the front of the pipe and
// bubbles MEM/WB until the access completes or times out.
//
// Handshake: dmem_req is held high with dmem_we/addr/wdata stable until the
// memory returns a single-cycle dmem_ack (dmem_rdata valid in that cycle) or
// TIMEOUT request cycles pass without one. dmem_ack outside REQ is ignored.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int MAW     = MAW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_valid,
  input  logic             mem_we,
  input  logic [MAW-1:0]   mem_addr,
  input  logic [DSIZE-1:0] mem_wdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [MAW-1:0]   dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             stall,
  output logic             mwb_bubble,
  output logic [DSIZE-1:0] load_data,
  output logic             load_valid,
  output logic             bus_err,
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_stall;
  logic             w_hit;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  logic             r_req;
  logic             r_we;
  logic [MAW-1:0]   r_addr;
  logic [DSIZE-1:0] r_wdata;
  logic [DSIZE-1:0] r_ld;
  logic             r_lv;
  logic             r_err;

  // A new access starts the wait count from zero; only ack-less REQ cycles count.
  assign w_cnt_clr = (r_state == ST_IDLE) && mem_req_valid;
  assign w_cnt_en  = (r_state == ST_REQ) && !dmem_ack;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_hit (w_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and stall decode; ack beats a timeout landing in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = mem_req_valid;
        if (mem_req_valid) w_next = ST_REQ;
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (dmem_ack)   w_next = ST_DONE;
        else if (w_hit) w_next = ST_ERR;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request/response registers: latch on issue, capture load data on ack,
  // zero load data and flag an error on timeout, drop flags when leaving DONE/ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ld    <= '0;
      r_lv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req_valid) begin
            r_req   <= 1'b1;
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_ld <= dmem_rdata;
              r_lv <= 1'b1;
            end
          end else if (w_hit) begin
            r_req <= 1'b0;
            r_ld  <= '0;
            r_err <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          r_lv  <= 1'b0;
          r_err <= 1'b0;
        end
        default: begin
          r_lv  <= 1'b0;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign load_data  = r_ld;
  assign load_valid = r_lv;
  assign bus_err    = r_err;
  assign stall      = w_stall;
  assign mwb_bubble = w_stall;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed accesses, a transaction-level
// reference model compared every cycle, and literal per-test expectations.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req_valid = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          stall;
  logic          mwb_bubble;
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          bus_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DSIZE   (DW),
    .MAW     (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .stall         (stall),
    .mwb_bubble    (mwb_bubble),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .bus_err       (bus_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  // m_wait: request cycles elapsed for the outstanding access (-1 = none).
  // m_retire: the cycle after an access finished, when MEM/WB captures it.
  int            m_wait   = -1;
  bit            m_retire = 1'b0;
  bit            m_live   = 1'b0;
  logic          e_req = 1'b0, e_we = 1'b0, e_lv = 1'b0, e_err = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ld = '0;

  always @(posedge clk) begin
    if (rst) begin
      e_req <= 1'b0; e_we <= 1'b0; e_addr <= '0; e_wdata <= '0;
      e_ld <= '0; e_lv <= 1'b0; e_err <= 1'b0;
      m_wait <= -1; m_retire <= 1'b0; m_live <= 1'b1;
    end else if (m_retire) begin
      m_retire <= 1'b0; e_lv <= 1'b0; e_err <= 1'b0;
    end else if (m_wait >= 0) begin
      if (dmem_ack) begin
        e_req <= 1'b0;
        if (!e_we) begin e_ld <= dmem_rdata; e_lv <= 1'b1; end
        m_wait <= -1; m_retire <= 1'b1;
      end else if (m_wait + 1 == TO) begin
        e_req <= 1'b0; e_ld <= '0; e_err <= 1'b1;
        m_wait <= -1; m_retire <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (mem_req_valid) begin
      e_req <= 1'b1; e_we <= mem_we; e_addr <= mem_addr; e_wdata <= mem_wdata;
      m_wait <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic       e_stall;
    logic [1:0] e_state;
    if (m_live) begin
      e_stall = (m_wait >= 0) || (!m_retire && mem_req_valid);
      e_state = m_retire ? (e_err ? ST_ERR : ST_DONE) : ((m_wait >= 0) ? ST_REQ : ST_IDLE);
      chk("dmem_req", dmem_req, e_req);
      chk("dmem_we", dmem_we, e_we);
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_wdata", dmem_wdata, e_wdata);
      chk("load_data", load_data, e_ld);
      chk("load_valid", load_valid, e_lv);
      chk("bus_err", bus_err, e_err);
      chk("stall", stall, e_stall);
      chk("mwb_bubble", mwb_bubble, e_stall);
      chk("state", dbg_state, e_state);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One access with ack on REQ cycle ack_at (0 = never); cycle 0 is the IDLE detect.
  task automatic run_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int ack_at, input logic [DW-1:0] rd,
                        output int n_st, output int n_rq, output int n_lv, output int n_er,
                        output logic [DW-1:0] ld_end);
    bit fin;
    fin = 1'b0; n_st = 0; n_rq = 0; n_lv = 0; n_er = 0; ld_end = '0;
    mem_req_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
    for (int k = 0; k < 40 && !fin; k++) begin
      dmem_ack   = (ack_at > 0) && (k == ack_at);
      dmem_rdata = dmem_ack ? rd : '0;
      @(negedge clk);
      if (stall)      n_st++;
      if (dmem_req)   n_rq++;
      if (load_valid) n_lv++;
      if (bus_err)    n_er++;
      if (dbg_state == ST_DONE || dbg_state == ST_ERR) begin
        fin = 1'b1;
        ld_end = load_data;
      end
      next_cycle();
    end
    dmem_ack = 1'b0; dmem_rdata = '0; mem_req_valid = 1'b0;
    if (!fin) chk("op_completes", 32'd0, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int            n_st, n_rq, n_lv, n_er;
    logic [DW-1:0] ld;
    int            first_done, rise2, rises, lv_cnt;
    logic          prev_req;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();

    // Load, ack on 2nd REQ cycle.
    run_op(1'b0, 8'h10, 16'h0000, 2, 16'hBEEF, n_st, n_rq, n_lv, n_er, ld);
    chk("ld_stall_cycles", n_st, 3);
    chk("ld_req_cycles", n_rq, 2);
    chk("ld_lv_pulses", n_lv, 1);
    chk("ld_err_pulses", n_er, 0);
    chk("ld_data", ld, 16'hBEEF);

    // Store, ack on 1st REQ cycle; load_data must keep the previous load.
    run_op(1'b1, 8'h20, 16'h1234, 1, 16'h5555, n_st, n_rq, n_lv, n_er, ld);
    chk("st_stall_cycles", n_st, 2);
    chk("st_req_cycles", n_rq, 1);
    chk("st_lv_pulses", n_lv, 0);
    chk("st_ld_kept", ld, 16'hBEEF);
    next_cycle();

    // No ack: timeout after 15 REQ cycles.
    run_op(1'b0, 8'h33, 16'h0000, 0, 16'h0000, n_st, n_rq, n_lv, n_er, ld);
    chk("to_stall_cycles", n_st, 16);
    chk("to_req_cycles", n_rq, 15);
    chk("to_err_pulses", n_er, 1);
    chk("to_lv_pulses", n_lv, 0);
    chk("to_ld_zero", ld, 16'h0000);

    // Ack in the cycle the counter reaches TIMEOUT: ack wins.
    run_op(1'b0, 8'h44, 16'h0000, 15, 16'hA5A5, n_st, n_rq, n_lv, n_er, ld);
    chk("edge_req_cycles", n_rq, 15);
    chk("edge_err_pulses", n_er, 0);
    chk("edge_lv_pulses", n_lv, 1);
    chk("edge_ld", ld, 16'hA5A5);

    // Reset on 2nd REQ cycle, late ack afterwards.
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 8'h30;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; mem_req_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    @(negedge clk);
    chk("mrst_req", dmem_req, 0);
    chk("mrst_addr", dmem_addr, 0);
    chk("mrst_ld", load_data, 0);
    chk("mrst_lv", load_valid, 0);
    chk("mrst_err", bus_err, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_state", dbg_state, ST_IDLE);
    next_cycle();
    dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    chk("mrst_late_ack_lv", load_valid, 0);
    chk("mrst_late_ack_state", dbg_state, ST_IDLE);
    next_cycle();

    // Two back-to-back loads with mem_req_valid held high.
    first_done = -1; rise2 = -1; rises = 0; lv_cnt = 0; prev_req = 1'b0;
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) mem_addr = 8'h41;
      if (k == 6) mem_req_valid = 1'b0;
      dmem_ack   = (k == 1) || (k == 4);
      dmem_rdata = (k == 1) ? 16'hCAFE : ((k == 4) ? 16'hF00D : 16'h0000);
      @(negedge clk);
      if (load_valid) lv_cnt++;
      if (dbg_state == ST_DONE && first_done < 0) first_done = k;
      if (dmem_req && !prev_req) begin
        rises++;
        if (rises == 2) rise2 = k;
      end
      prev_req = dmem_req;
      if (k == 2) begin
        chk("b2b_done_req", dmem_req, 0);
        chk("b2b_done_stall", stall, 0);
        chk("b2b_first_data", load_data, 16'hCAFE);
      end
      if (k == 5) chk("b2b_second_data", load_data, 16'hF00D);
      next_cycle();
    end
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("b2b_lv_pulses", lv_cnt, 2);
    chk("b2b_first_done", first_done, 2);
    chk("b2b_req_gap", rise2 - first_done, 2);

    repeat (2) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
